// File: rtl/game2048_core.sv
// N x N 2048 engine: tiles stored as exponents, one line shifted/merged per cycle,
// LFSR-driven tile spawn after changing moves, score keeping and win/lose detection.
module game2048_core #(
   parameter int          N         = 4,
   parameter int          EW        = 4,
   parameter int          WIN_EXP   = 11,
   parameter int          SCORE_W   = 20,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  up,
   input  logic                  down,
   input  logic                  left,
   input  logic                  right,
   output logic [N*N*EW-1:0]     board_flat,
   output logic [SCORE_W-1:0]    score,
   output logic                  busy,
   output logic                  q_Init,
   output logic                  q_Wait,
   output logic                  q_Shift,
   output logic                  q_Spawn,
   output logic                  q_Check,
   output logic                  q_Win,
   output logic                  q_Lose
);
   localparam int NN = N * N;
   localparam int LW = $clog2(N);
   localparam int SW = $clog2(NN);
   localparam int GW = SCORE_W + 4;

   typedef enum logic [2:0] {S_INIT, S_WAIT, S_SHIFT, S_SPAWN, S_CHECK, S_WIN, S_LOSE} state_t;
   typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

   state_t              r_state;
   dir_t                r_dir;
   logic [NN*EW-1:0]    r_board;
   logic [SCORE_W-1:0]  r_score;
   logic [15:0]         r_lfsr;
   logic [LW-1:0]       r_line;
   logic [SW-1:0]       r_scan;
   logic [SW-1:0]       r_cnt;
   logic                r_changed;

   logic [EW-1:0]       w_old [N];
   logic [EW-1:0]       w_new [N];
   logic [NN*EW-1:0]    w_board_shift;
   logic [SCORE_W-1:0]  w_score_shift;
   logic                w_line_diff;
   logic                w_win;
   logic                w_empty;
   logic                w_pair;
   logic [EW-1:0]       w_scan_cell;
   logic [SW-1:0]       w_start;
   logic [SW-1:0]       w_scan_next;
   logic                w_fb;

   // Position i along line k, counted from the destination edge, mapped to a cell index.
   function automatic int unsigned cell_idx(input dir_t d, input int unsigned k, input int unsigned i);
      case (d)
         D_UP:    return i * N + k;
         D_DOWN:  return (N - 1 - i) * N + k;
         D_LEFT:  return k * N + i;
         default: return k * N + (N - 1 - i);
      endcase
   endfunction

   always_comb begin : p_shift
      int unsigned   pos;
      logic          mergeable;
      logic [EW-1:0] v;
      logic [EW-1:0] last;
      logic [EW-1:0] merged;
      logic [GW-1:0] gain;
      logic [GW-1:0] tot;
      logic          sat;
      pos       = 0;
      mergeable = 1'b0;
      v         = '0;
      last      = '0;
      merged    = '0;
      gain      = '0;
      sat       = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         w_old[i] = '0;
         w_new[i] = '0;
      end
      for (int unsigned i = 0; i < N; i++)
         for (int unsigned j = 0; j < NN; j++)
            if (j == cell_idx(r_dir, 32'(r_line), i)) w_old[i] = r_board[j*EW +: EW];
      // A freshly merged tile clears 'mergeable', so it cannot absorb the next equal tile.
      for (int unsigned i = 0; i < N; i++) begin
         v = w_old[i];
         if (v != '0) begin
            if (mergeable && v == last) begin
               merged = (v == '1) ? v : v + 1'b1;
               for (int unsigned j = 0; j < N; j++)
                  if (j + 1 == pos) w_new[j] = merged;
               if (int'(v) + 1 >= SCORE_W) sat = 1'b1;
               else gain = gain + (GW'(1) << (int'(v) + 1));
               mergeable = 1'b0;
            end else begin
               for (int unsigned j = 0; j < N; j++)
                  if (j == pos) w_new[j] = v;
               last      = v;
               mergeable = 1'b1;
               pos++;
            end
         end
      end
      w_line_diff = 1'b0;
      for (int unsigned i = 0; i < N; i++)
         if (w_new[i] != w_old[i]) w_line_diff = 1'b1;
      w_board_shift = r_board;
      for (int unsigned i = 0; i < N; i++)
         for (int unsigned j = 0; j < NN; j++)
            if (j == cell_idx(r_dir, 32'(r_line), i)) w_board_shift[j*EW +: EW] = w_new[i];
      tot           = GW'(r_score) + gain;
      w_score_shift = (sat || tot[GW-1:SCORE_W] != '0) ? '1 : tot[SCORE_W-1:0];
   end

   always_comb begin : p_check
      w_win   = 1'b0;
      w_empty = 1'b0;
      w_pair  = 1'b0;
      for (int unsigned j = 0; j < NN; j++) begin
         if (int'(r_board[j*EW +: EW]) >= WIN_EXP) w_win = 1'b1;
         if (r_board[j*EW +: EW] == '0) w_empty = 1'b1;
      end
      for (int unsigned r = 0; r < N; r++)
         for (int unsigned c = 0; c + 1 < N; c++) begin
            if (r_board[(r*N+c)*EW +: EW] == r_board[(r*N+c+1)*EW +: EW]) w_pair = 1'b1;
            if (r_board[(c*N+r)*EW +: EW] == r_board[((c+1)*N+r)*EW +: EW]) w_pair = 1'b1;
         end
   end

   always_comb begin : p_spawn
      w_scan_cell = '0;
      for (int unsigned j = 0; j < NN; j++)
         if (j == 32'(r_scan)) w_scan_cell = r_board[j*EW +: EW];
      w_start     = SW'(r_lfsr % 16'(NN));
      w_scan_next = (32'(r_scan) == NN - 1) ? '0 : r_scan + 1'b1;
      w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= S_INIT;
         r_board   <= '0;
         r_score   <= '0;
         r_lfsr    <= LFSR_SEED;
         r_dir     <= D_LEFT;
         r_changed <= 1'b0;
         r_line    <= '0;
         r_scan    <= '0;
         r_cnt     <= '0;
      end else begin
         r_lfsr <= {r_lfsr[14:0], w_fb};
         case (r_state)
            S_INIT: begin
               r_board   <= '0;
               r_score   <= '0;
               r_changed <= 1'b1;
               r_scan    <= w_start;
               r_cnt     <= '0;
               r_state   <= S_SPAWN;
            end
            S_WAIT: begin
               if (up || down || left || right) begin
                  r_dir     <= up ? D_UP : down ? D_DOWN : left ? D_LEFT : D_RIGHT;
                  r_line    <= '0;
                  r_changed <= 1'b0;
                  r_state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_board   <= w_board_shift;
               r_score   <= w_score_shift;
               r_changed <= r_changed | w_line_diff;
               if (32'(r_line) == N - 1) begin
                  r_scan  <= w_start;
                  r_cnt   <= '0;
                  r_state <= (r_changed || w_line_diff) ? S_SPAWN : S_CHECK;
               end else begin
                  r_line <= r_line + 1'b1;
               end
            end
            S_SPAWN: begin
               if (w_scan_cell == '0) begin
                  for (int unsigned j = 0; j < NN; j++)
                     if (j == 32'(r_scan))
                        r_board[j*EW +: EW] <= (r_lfsr[2:0] == 3'b000) ? EW'(2) : EW'(1);
                  r_state <= S_CHECK;
               end else begin
                  r_scan <= w_scan_next;
                  r_cnt  <= r_cnt + 1'b1;
                  if (32'(r_cnt) == NN - 1) r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (w_win)                    r_state <= S_WIN;
               else if (!w_empty && !w_pair) r_state <= S_LOSE;
               else                          r_state <= S_WAIT;
            end
            default: ;
         endcase
      end
   end

   assign board_flat = r_board;
   assign score      = r_score;
   assign q_Init     = (r_state == S_INIT);
   assign q_Wait     = (r_state == S_WAIT);
   assign q_Shift    = (r_state == S_SHIFT);
   assign q_Spawn    = (r_state == S_SPAWN);
   assign q_Check    = (r_state == S_CHECK);
   assign q_Win      = (r_state == S_WIN);
   assign q_Lose     = (r_state == S_LOSE);
   assign busy       = !(q_Wait || q_Win || q_Lose);

endmodule
